// File: rtl/boot_rom_loader.sv
// boot_rom_loader: copies a block of 32-bit words from the boot ROM read port into a data-RAM write port.
// Ports: clk, rst_n (async active-low); start_i/src_base_i/dst_base_i/word_count_i describe the copy;
// busy_o/done_o/checksum_o report progress; rom_en_o/rom_addr_o/rom_rdata_i drive the ROM read port;
// ram_req_o/ram_gnt_i/ram_addr_o/ram_we_o/ram_be_o/ram_wdata_o drive the RAM write port.
module boot_rom_loader #(
    parameter int ROM_ADDR_WIDTH = 10,
    parameter int RAM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [ROM_ADDR_WIDTH-1:0] src_base_i,
    input  logic [RAM_ADDR_WIDTH-1:0] dst_base_i,
    input  logic [ROM_ADDR_WIDTH:0]   word_count_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [31:0]               checksum_o,
    output logic                      rom_en_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i,
    output logic                      ram_req_o,
    input  logic                      ram_gnt_i,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [31:0]               ram_wdata_o
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;
    state_t state, state_nx;
    logic [ROM_ADDR_WIDTH-1:0] src;
    logic [RAM_ADDR_WIDTH-1:0] dst;
    logic [ROM_ADDR_WIDTH:0]   cnt;
    logic [31:0]               data;
    logic [31:0]               sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            data  <= '0;
            sum   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_i) begin
                sum <= '0;
                if (word_count_i != '0) begin
                    src <= src_base_i;
                    dst <= dst_base_i & ~RAM_ADDR_WIDTH'(3);
                    cnt <= word_count_i;
                end
            end
            if (state == WAIT) begin
                data <= rom_rdata_i;
                sum  <= sum + rom_rdata_i;
            end
            if (state == WR && ram_gnt_i) begin
                src <= src + ROM_ADDR_WIDTH'(1);
                dst <= dst + RAM_ADDR_WIDTH'(4);
                cnt <= cnt - (ROM_ADDR_WIDTH + 1)'(1);
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_i ? ((word_count_i == '0) ? DONE : RD) : IDLE;
            RD:      state_nx = WAIT;
            WAIT:    state_nx = WR;
            WR:      state_nx = ram_gnt_i ? ((cnt == (ROM_ADDR_WIDTH + 1)'(1)) ? DONE : RD) : WR;
            default: state_nx = IDLE;
        endcase
    end
    assign busy_o      = (state == RD) || (state == WAIT) || (state == WR);
    assign done_o      = (state == DONE);
    assign rom_en_o    = (state == RD);
    assign ram_req_o   = (state == WR);
    assign ram_we_o    = ram_req_o;
    assign ram_be_o    = {4{ram_req_o}};
    assign rom_addr_o  = src;
    assign ram_addr_o  = dst;
    assign ram_wdata_o = data;
    assign checksum_o  = sum;
endmodule

// File: tb/tb_boot_rom_loader.sv
// tb_boot_rom_loader: directed bench for boot_rom_loader with a transaction-level scoreboard model.
module tb_boot_rom_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  src_base;
    logic [31:0] dst_base;
    logic [10:0] word_count;
    logic        busy_o, done_o, rom_en_o, ram_req_o, ram_we_o;
    logic [31:0] checksum_o, ram_addr_o, ram_wdata_o;
    logic [9:0]  rom_addr_o;
    logic [31:0] rom_rdata;
    logic        ram_gnt;
    logic [3:0]  ram_be_o;
    logic [31:0] rom_mem [1024];
    logic [9:0]  exp_rd[$], seen_rd[$];
    logic [63:0] exp_wr[$], seen_wr[$];
    logic [31:0] exp_sum;
    int          n_cmp = 0, n_bad = 0;
    int          dc, bc;

    boot_rom_loader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .src_base_i(src_base),
        .dst_base_i(dst_base), .word_count_i(word_count), .busy_o(busy_o),
        .done_o(done_o), .checksum_o(checksum_o), .rom_en_o(rom_en_o),
        .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata), .ram_req_o(ram_req_o),
        .ram_gnt_i(ram_gnt), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o)
    );

    always #5 clk = ~clk;

    // synchronous-read ROM the loader talks to
    always @(posedge clk) if (rom_en_o) rom_rdata <= rom_mem[rom_addr_o];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // expected ROM read order, RAM write list and checksum for a copy
    task automatic model(input logic [9:0] src, input logic [31:0] dst, input int n);
        logic [9:0]  a;
        logic [31:0] d;
        exp_rd.delete(); exp_wr.delete(); seen_rd.delete(); seen_wr.delete();
        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            a = src + 10'(i);
            d = rom_mem[a];
            exp_sum += d;
            exp_rd.push_back(a);
            exp_wr.push_back({(dst & ~32'h3) + 32'(4 * i), d});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_en_o) begin
                seen_rd.push_back(rom_addr_o);
                chk("rom_read_expected", 64'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) chk("rom_addr", rom_addr_o, exp_rd.pop_front());
                chk("rom_en_busy", busy_o, 1);
            end
            if (ram_req_o) begin
                chk("ram_write_expected", 64'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    chk("ram_addr", ram_addr_o, exp_wr[0][63:32]);
                    chk("ram_wdata", ram_wdata_o, exp_wr[0][31:0]);
                    if (ram_gnt) begin
                        void'(exp_wr.pop_front());
                        seen_wr.push_back({ram_addr_o, ram_wdata_o});
                    end
                end
                chk("ram_we_be_busy", {ram_we_o, ram_be_o, busy_o}, {1'b1, 4'hF, 1'b1});
            end else begin
                chk("ram_idle_we_be", {ram_we_o, ram_be_o}, 5'b0);
            end
            if (done_o) begin
                chk("done_not_busy", busy_o, 0);
                chk("done_writes_left", exp_wr.size(), 0);
                chk("done_reads_left", exp_rd.size(), 0);
                chk("done_checksum", checksum_o, exp_sum);
            end
        end
    end

    task automatic run_copy(input logic [9:0] src, input logic [31:0] dst, input int n,
                            input int stall_at, input int stall_len, input bit restart,
                            output int done_cyc, output int busy_cyc);
        model(src, dst, n);
        done_cyc = 0;
        busy_cyc = 0;
        @(posedge clk); #1;
        src_base = src; dst_base = dst; word_count = 11'(n); start = 1'b1; ram_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; src_base = 10'h155; dst_base = 32'hDEAD_0000; word_count = 11'd7;
        for (int k = 1; k <= 300; k++) begin
            ram_gnt = !(k >= stall_at && k < stall_at + stall_len);
            start = restart && k == 5;
            if (start) begin word_count = 11'd1; src_base = 10'h200; end
            @(negedge clk);
            busy_cyc += int'(busy_o);
            if (done_o) begin done_cyc = k; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0; ram_gnt = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
        for (int i = 0; i < 4; i++) rom_mem[16 + i] = 32'(i + 1);
        rom_mem[1023] = 32'hDEAD_BEEF;
        rom_mem[0]    = 32'h1111_0000;
        rst_n = 1'b0; start = 1'b0; ram_gnt = 1'b1;
        src_base = '0; dst_base = '0; word_count = '0;
        #1;
        chk("reset_ctrl", {busy_o, done_o, rom_en_o, ram_req_o, ram_we_o}, 5'b0);
        chk("reset_be", ram_be_o, 4'h0);
        chk("reset_addrs", {rom_addr_o, ram_addr_o}, 42'h0);
        chk("reset_wdata_sum", {ram_wdata_o, checksum_o}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_copy(10'h010, 32'h1000_0000, 4, 0, 0, 1'b0, dc, bc);
        chk("t1_done_cycle", dc, 13);
        chk("t1_busy_cycles", bc, 12);
        chk("t1_checksum", checksum_o, 32'd10);
        chk("t1_writes", seen_wr.size(), 4);
        if (seen_wr.size() == 4) chk("t1_last_write", seen_wr[3], {32'h1000_000C, 32'd4});

        run_copy(10'h010, 32'h1000_0000, 4, 6, 3, 1'b0, dc, bc);
        chk("t2_done_cycle", dc, 16);
        chk("t2_writes", seen_wr.size(), 4);
        if (seen_wr.size() == 4) chk("t2_second_write", seen_wr[1], {32'h1000_0004, 32'd2});

        run_copy(10'h005, 32'h4000_0000, 0, 0, 0, 1'b0, dc, bc);
        chk("t3_done_cycle", dc, 1);
        chk("t3_busy_cycles", bc, 0);
        chk("t3_checksum", checksum_o, 32'd0);
        chk("t3_no_access", seen_rd.size() + seen_wr.size(), 0);

        run_copy(10'h3FF, 32'hFFFF_FFFE, 2, 0, 0, 1'b0, dc, bc);
        chk("t4_done_cycle", dc, 7);
        chk("t4_reads", seen_rd.size(), 2);
        if (seen_rd.size() == 2) chk("t4_rom_addrs", {seen_rd[0], seen_rd[1]}, {10'h3FF, 10'h000});
        if (seen_wr.size() == 2) chk("t4_ram_wrap", seen_wr[1][63:32], 32'h0000_0000);
        chk("t4_checksum", checksum_o, 32'hEFBE_BEEF);

        run_copy(10'h010, 32'h2000_0000, 4, 0, 0, 1'b1, dc, bc);
        chk("t5_done_cycle", dc, 13);
        chk("t5_writes", seen_wr.size(), 4);
        chk("t5_checksum", checksum_o, 32'd10);

        model(10'h010, 32'h2000_0000, 4);
        @(posedge clk); #1;
        src_base = 10'h010; dst_base = 32'h2000_0000; word_count = 11'd4; start = 1'b1; ram_gnt = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_in_wr", ram_req_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", {busy_o, done_o, rom_en_o, ram_req_o, ram_we_o}, 5'b0);
        chk("t6_rst_be", ram_be_o, 4'h0);
        chk("t6_rst_addrs", {rom_addr_o, ram_addr_o}, 42'h0);
        chk("t6_rst_wdata_sum", {ram_wdata_o, checksum_o}, 64'h0);
        exp_rd.delete(); exp_wr.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; ram_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_idle_after_reset", {busy_o, done_o, rom_en_o, ram_req_o}, 4'b0);
        end
        run_copy(10'h010, 32'h3000_0000, 4, 0, 0, 1'b0, dc, bc);
        chk("t6_fresh_done_cycle", dc, 13);
        chk("t6_fresh_checksum", checksum_o, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/boot_rom_loader.md
# boot_rom_loader

Initiator for the boot ROM's synchronous read port, driving the same `en`/`addr`/`rdata` interface from the master side. On a start pulse it reads a block of 32-bit words from boot ROM and writes them into a data-RAM port using a req/gnt handshake. It reports busy and done, and keeps a running checksum. It sits between the boot ROM wrapper and the RAM bus so boot code can be copied into RAM before the core is released from fetch stall.

## Interface
- `ROM_ADDR_WIDTH`, default 10: ROM word-address width.
- `RAM_ADDR_WIDTH`, default 32: RAM byte-address width.
- `clk` in, 1: clock, rising edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `start_i` in, 1: start request, sampled in IDLE only.
- `src_base_i` in, ROM_ADDR_WIDTH: first ROM word address, latched on start.
- `dst_base_i` in, RAM_ADDR_WIDTH: first RAM byte address (bits [1:0] ignored), latched on start.
- `word_count_i` in, ROM_ADDR_WIDTH+1: number of words to copy, latched on start.
- `busy_o` out, 1: copy in progress.
- `done_o` out, 1: one-cycle completion pulse.
- `checksum_o` out, 32: sum of copied words, modulo 2^32.
- `rom_en_o` out, 1: ROM read enable.
- `rom_addr_o` out, ROM_ADDR_WIDTH: ROM word address.
- `rom_rdata_i` in, 32: ROM data, valid the cycle after `rom_en_o`.
- `ram_req_o` out, 1: RAM write request.
- `ram_gnt_i` in, 1: RAM grant.
- `ram_addr_o` out, RAM_ADDR_WIDTH: RAM byte address, word aligned.
- `ram_we_o` out, 1: always 1 while `ram_req_o` is high, else 0.
- `ram_be_o` out, 4: 4'hF while `ram_req_o` is high, else 4'h0.
- `ram_wdata_o` out, 32: write data.

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE, `start_i`=1, `word_count_i`≠0: latch the three inputs, clear the checksum, go to RD.
- IDLE, `start_i`=1, `word_count_i`=0: clear the checksum, go to DONE. No ROM or RAM access occurs.
- RD: `rom_en_o`=1, `rom_addr_o`=current source address. Go to WAIT.
- WAIT: capture `rom_rdata_i` into the data register and add it to the checksum. Go to WR.
- WR: `ram_req_o`=1 with address and data from the registers.
  - No grant: stay in WR; all RAM outputs held stable.
  - Grant: source address +1 (wraps modulo 2^ROM_ADDR_WIDTH), destination +4 (wraps modulo 2^RAM_ADDR_WIDTH), remaining count −1.
  - Then go to DONE if remaining count was 1, else RD.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `busy_o`=1 in RD, WAIT and WR; 0 in IDLE and DONE.
- `start_i` outside IDLE is ignored; it is not queued.
- `checksum_o` updates as each word is captured. It is final when `done_o` rises and holds until the next accepted start.
- Reset mid-copy: every state, counter and output returns to its reset value immediately. No further ROM or RAM access occurs, and no `done_o` pulse is produced.

## Timing
- Reset values:
  - `busy_o`, `done_o`, `rom_en_o`, `ram_req_o`, `ram_we_o`: 0.
  - `ram_be_o`: 0.
  - `rom_addr_o`, `ram_addr_o`, `ram_wdata_o`, `checksum_o`: 0.
  - FSM state: IDLE.
- `rom_en_o` is never asserted outside RD, and `ram_req_o` never outside WR.
- Start sampled at edge 0:
  - RD in cycle 1.
  - ROM data captured at the end of cycle 2.
  - `ram_req_o` high in cycle 3.
- Zero-wait grant: 3 cycles per word. N words with immediate grant give `done_o` in cycle 3N+1.
- Each cycle of grant stall adds one cycle.
- `done_o` asserts the cycle after the final grant.
- A new start is accepted no earlier than the cycle after `done_o`.
- All outputs are registered or decoded directly from FSM state; there are no combinational paths from inputs to outputs.

## Test plan
- Copy 4 words with `src_base_i`=0x010, `dst_base_i`=0x1000_0000, ROM words 1,2,3,4, and `ram_gnt_i` tied high.
  - RAM writes to 0x1000_0000/04/08/0C with data 1,2,3,4.
  - `done_o` in cycle 13; `checksum_o`=10; `busy_o` high for cycles 1–12.
- Same 4-word copy, with `ram_gnt_i` low for 3 cycles on the second write.
  - Address and data held stable through the stall; `done_o` in cycle 16; `ram_be_o`=4'hF during each request.
- `word_count_i`=0.
  - `done_o` in cycle 1; `busy_o` stays 0; no `rom_en_o` or `ram_req_o`; `checksum_o`=0.
- `src_base_i`=2^ROM_ADDR_WIDTH−1 with a count of 2.
  - ROM addresses 0x3FF then 0x000.
- `start_i` pulsed again mid-copy.
  - Ignored; the original count completes unchanged.
- `rst_n` asserted while in WR with the grant low.
  - All outputs 0 immediately; after release the FSM is in IDLE; no `done_o`; a fresh copy then completes normally.
